// File: rtl/seqdet_pkg.sv
// Shared types and default widths for the sequence-detector event monitor.
package seqdet_pkg;

  // Window FSM state encoding.
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_e;

  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 16;

endpackage

// File: rtl/seqdet_rpt_reg.sv
// Single-entry report register: loads a closed window's result when the slot
// is free or being drained this cycle, otherwise drops it and remembers the loss.
module seqdet_rpt_reg
  import seqdet_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_count_i,
  input  logic             load_sat_i,
  input  logic             rpt_ready_i,
  output logic             rpt_valid_o,
  output logic [CNT_W-1:0] rpt_count_o,
  output logic             rpt_sat_o,
  output logic             rpt_lost_o
);

  logic             valid_q;
  logic [CNT_W-1:0] count_q;
  logic             sat_q;
  logic             lost_q;
  logic             sticky_lost_q;
  logic             consume;

  // A ready with nothing pending is meaningless and must not be treated as a drain.
  assign consume = valid_q && rpt_ready_i;

  // Load/drop decision, handshake drain and sticky-lost tracking.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset lives inside the clocked block, so it also wins over a same-cycle handshake.
    if (rst) begin
      valid_q       <= 1'b0;
      count_q       <= '0;
      sat_q         <= 1'b0;
      lost_q        <= 1'b0;
      sticky_lost_q <= 1'b0;
    end else if (load_i && (!valid_q || consume)) begin
      valid_q       <= 1'b1;
      count_q       <= load_count_i;
      sat_q         <= load_sat_i;
      lost_q        <= sticky_lost_q;
      sticky_lost_q <= 1'b0;
    end else if (load_i) begin
      // Slot still owned by the consumer: this window's result is lost.
      sticky_lost_q <= 1'b1;
    end else if (consume) begin
      valid_q <= 1'b0;
    end
  end

  assign rpt_valid_o = valid_q;
  assign rpt_count_o = count_q;
  assign rpt_sat_o   = sat_q;
  assign rpt_lost_o  = lost_q;

endmodule

// File: rtl/seqdet_event_monitor.sv
// Counts detector hits over back-to-back programmable windows and hands one
// report per window to the report register.
module seqdet_event_monitor
  import seqdet_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIN_W-1:0] win_len,
  input  logic             det_in,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_count,
  output logic             rpt_sat,
  output logic             rpt_lost,
  output logic             busy
);

  localparam logic [CNT_W-1:0] HIT_MAX = '1;
  localparam logic [WIN_W-1:0] LEN_ONE = WIN_W'(1);

  state_e           state_q;
  logic [WIN_W-1:0] len_q;
  logic [WIN_W-1:0] cyc_q;
  logic [CNT_W-1:0] hit_q;
  logic [CNT_W-1:0] hit_d;
  logic             sat_q;
  logic             sat_d;
  logic [WIN_W-1:0] len_d;
  logic             close_c;

  // A zero window length is treated as a one-cycle window.
  assign len_d = (win_len == '0) ? LEN_ONE : win_len;

  // Saturating hit update for this cycle's det_in, plus the window-close decode.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    hit_d = hit_q;
    sat_d = sat_q;
    if (det_in) begin
      if (hit_q == HIT_MAX) sat_d = 1'b1;
      else                  hit_d = hit_q + 1'b1;
    end
    close_c = (state_q == ST_COUNT) && en && (cyc_q == len_q - 1'b1);
  end

  // Window FSM: start, count, close-and-restart, abort.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cyc_q   <= '0;
      hit_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_q <= ST_COUNT;
            len_q   <= len_d;
            cyc_q   <= '0;
            hit_q   <= '0;
            sat_q   <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (!en) begin
            // Abort: partial window is discarded, pending report is untouched.
            state_q <= ST_IDLE;
            cyc_q   <= '0;
            hit_q   <= '0;
            sat_q   <= 1'b0;
          end else if (close_c) begin
            // Next window starts on the very next cycle with a fresh length.
            len_q <= len_d;
            cyc_q <= '0;
            hit_q <= '0;
            sat_q <= 1'b0;
          end else begin
            cyc_q <= cyc_q + 1'b1;
            hit_q <= hit_d;
            sat_q <= sat_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_q == ST_COUNT);

  // The closing cycle's det_in is folded into the reported count via hit_d/sat_d.
  seqdet_rpt_reg #(
    .CNT_W(CNT_W)
  ) u_rpt_reg (
    .clk          (clk),
    .rst          (rst),
    .load_i       (close_c),
    .load_count_i (hit_d),
    .load_sat_i   (sat_d),
    .rpt_ready_i  (rpt_ready),
    .rpt_valid_o  (rpt_valid),
    .rpt_count_o  (rpt_count),
    .rpt_sat_o    (rpt_sat),
    .rpt_lost_o   (rpt_lost)
  );

endmodule

// File: tb/tb_seqdet_event_monitor.sv
// Directed bench for seqdet_event_monitor; a second 4-bit-count instance
// shares the inputs to exercise saturation.
module tb_seqdet_event_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] win_len = '0;
  logic        det_in = 1'b0;
  logic        rpt_ready = 1'b0;

  logic        rpt_valid, rpt_sat, rpt_lost, busy;
  logic [7:0]  rpt_count;
  logic        rpt_valid4, rpt_sat4, rpt_lost4, busy4;
  logic [3:0]  rpt_count4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seqdet_event_monitor #(.CNT_W(8), .WIN_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .win_len(win_len), .det_in(det_in),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_count(rpt_count),
    .rpt_sat(rpt_sat), .rpt_lost(rpt_lost), .busy(busy)
  );

  seqdet_event_monitor #(.CNT_W(4), .WIN_W(16)) dut4 (
    .clk(clk), .rst(rst), .en(en), .win_len(win_len), .det_in(det_in),
    .rpt_valid(rpt_valid4), .rpt_ready(rpt_ready), .rpt_count(rpt_count4),
    .rpt_sat(rpt_sat4), .rpt_lost(rpt_lost4), .busy(busy4)
  );

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; det_in = 1'b0; rpt_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  // Drive n window cycles, det_in taken from mask bit k on cycle k.
  task automatic drive_window(input int n, input logic [31:0] mask);
    for (int k = 0; k < n; k++) begin
      det_in = mask[k];
      tick();
    end
    det_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rpt_valid); end
    total++; if (rpt_count !== 8'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", rpt_count); end
    total++; if (rpt_sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b want 0", rpt_sat); end
    total++; if (rpt_lost !== 1'b0) begin bad++; $display("FAIL reset_lost: got %b want 0", rpt_lost); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    do_reset();
    en = 1'b1; win_len = 16'd10; rpt_ready = 1'b1;
    tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    drive_window(9, 32'h0000_0024);
    total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid: got %b want 0", rpt_valid); end
    det_in = 1'b1; tick(); det_in = 1'b0;
    total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %b want 1", rpt_valid); end
    total++; if (rpt_count !== 8'd3) begin bad++; $display("FAIL basic_count: got %0d want 3", rpt_count); end
    total++; if (rpt_sat !== 1'b0) begin bad++; $display("FAIL basic_sat: got %b want 0", rpt_sat); end
    total++; if (rpt_lost !== 1'b0) begin bad++; $display("FAIL basic_lost: got %b want 0", rpt_lost); end
    // Second window: hits on cycles 0 and 9.
    det_in = 1'b1; tick(); det_in = 1'b0;
    total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL basic_drain: got %b want 0", rpt_valid); end
    drive_window(9, 32'h0000_0100);
    total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL basic_w2_valid: got %b want 1", rpt_valid); end
    total++; if (rpt_count !== 8'd2) begin bad++; $display("FAIL basic_w2_count: got %0d want 2", rpt_count); end
    en = 1'b0; tick();
  endtask

  task automatic test_saturation();
    do_reset();
    en = 1'b1; win_len = 16'd20; rpt_ready = 1'b1; det_in = 1'b1;
    tick();
    drive_window(20, 32'h000F_FFFF);
    total++; if (rpt_valid4 !== 1'b1) begin bad++; $display("FAIL sat_valid4: got %b want 1", rpt_valid4); end
    total++; if (rpt_count4 !== 4'd15) begin bad++; $display("FAIL sat_count4: got %0d want 15", rpt_count4); end
    total++; if (rpt_sat4 !== 1'b1) begin bad++; $display("FAIL sat_flag4: got %b want 1", rpt_sat4); end
    total++; if (rpt_count !== 8'd20) begin bad++; $display("FAIL sat_count8: got %0d want 20", rpt_count); end
    total++; if (rpt_sat !== 1'b0) begin bad++; $display("FAIL sat_flag8: got %b want 0", rpt_sat); end
    en = 1'b0; tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1; win_len = 16'd4; rpt_ready = 1'b0;
    tick();
    drive_window(4, 32'h1);
    total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL bp_w1_valid: got %b want 1", rpt_valid); end
    total++; if (rpt_count !== 8'd1) begin bad++; $display("FAIL bp_w1_count: got %0d want 1", rpt_count); end
    drive_window(4, 32'h3);
    total++; if (rpt_count !== 8'd1) begin bad++; $display("FAIL bp_w2_held: got %0d want 1", rpt_count); end
    drive_window(4, 32'h7);
    total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL bp_w3_valid: got %b want 1", rpt_valid); end
    total++; if (rpt_count !== 8'd1) begin bad++; $display("FAIL bp_w3_held: got %0d want 1", rpt_count); end
    rpt_ready = 1'b1;
    det_in = 1'b1; tick(); det_in = 1'b0;
    total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL bp_drain: got %b want 0", rpt_valid); end
    drive_window(3, 32'h7);
    total++; if (rpt_count !== 8'd4) begin bad++; $display("FAIL bp_w4_count: got %0d want 4", rpt_count); end
    total++; if (rpt_lost !== 1'b1) begin bad++; $display("FAIL bp_w4_lost: got %b want 1", rpt_lost); end
    drive_window(4, 32'h0);
    total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL bp_w5_valid: got %b want 1", rpt_valid); end
    total++; if (rpt_count !== 8'd0) begin bad++; $display("FAIL bp_w5_count: got %0d want 0", rpt_count); end
    total++; if (rpt_lost !== 1'b0) begin bad++; $display("FAIL bp_w5_lost: got %b want 0", rpt_lost); end
    en = 1'b0; rpt_ready = 1'b0; tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    en = 1'b1; win_len = 16'd4; rpt_ready = 1'b0;
    tick();
    drive_window(4, 32'h1);
    total++; if (rpt_count !== 8'd1) begin bad++; $display("FAIL b2b_w1_count: got %0d want 1", rpt_count); end
    for (int k = 0; k < 4; k++) begin
      det_in = (k == 1 || k == 2);
      rpt_ready = (k == 3);
      tick();
      total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid_c%0d: got %b want 1", k, rpt_valid); end
    end
    rpt_ready = 1'b0; det_in = 1'b0;
    total++; if (rpt_count !== 8'd2) begin bad++; $display("FAIL b2b_w2_count: got %0d want 2", rpt_count); end
    total++; if (rpt_lost !== 1'b0) begin bad++; $display("FAIL b2b_w2_lost: got %b want 0", rpt_lost); end
    tick();
    total++; if (rpt_valid !== 1'b1 || rpt_count !== 8'd2) begin bad++; $display("FAIL b2b_hold: got valid=%b count=%0d want valid=1 count=2", rpt_valid, rpt_count); end
    en = 1'b0; tick();
  endtask

  task automatic test_abort();
    do_reset();
    en = 1'b1; win_len = 16'd8; rpt_ready = 1'b1;
    tick();
    drive_window(5, 32'h0A);
    en = 1'b0; tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL abort_no_rpt: got %b want 0", rpt_valid); end
    en = 1'b1; tick();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_restart_busy: got %b want 1", busy); end
    drive_window(7, 32'h0);
    total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL abort_early_valid: got %b want 0", rpt_valid); end
    det_in = 1'b1; tick(); det_in = 1'b0;
    total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL abort_new_valid: got %b want 1", rpt_valid); end
    total++; if (rpt_count !== 8'd1) begin bad++; $display("FAIL abort_new_count: got %0d want 1", rpt_count); end
    en = 1'b0; tick();
  endtask

  task automatic test_win_zero();
    logic [4:0] pat;
    pat = 5'b01101;
    do_reset();
    en = 1'b1; win_len = 16'd0; rpt_ready = 1'b1;
    tick();
    for (int k = 0; k < 5; k++) begin
      det_in = pat[k];
      tick();
      total++; if (rpt_valid !== 1'b1) begin bad++; $display("FAIL wz_valid_c%0d: got %b want 1", k, rpt_valid); end
      total++; if (rpt_count !== {7'd0, pat[k]}) begin bad++; $display("FAIL wz_count_c%0d: got %0d want %0d", k, rpt_count, pat[k]); end
    end
    det_in = 1'b0; en = 1'b0; tick();
  endtask

  task automatic test_mid_reset();
    do_reset();
    en = 1'b1; win_len = 16'd4; rpt_ready = 1'b0;
    tick();
    drive_window(4, 32'hF);
    total++; if (rpt_valid !== 1'b1 || rpt_count !== 8'd4) begin bad++; $display("FAIL mr_pre: got valid=%b count=%0d want valid=1 count=4", rpt_valid, rpt_count); end
    det_in = 1'b1; tick(); tick();
    rst = 1'b1; rpt_ready = 1'b1;
    tick();
    total++; if (rpt_valid !== 1'b0) begin bad++; $display("FAIL mr_valid: got %b want 0", rpt_valid); end
    total++; if (rpt_count !== 8'd0) begin bad++; $display("FAIL mr_count: got %0d want 0", rpt_count); end
    total++; if (rpt_sat !== 1'b0 || rpt_lost !== 1'b0) begin bad++; $display("FAIL mr_flags: got sat=%b lost=%b want 0 0", rpt_sat, rpt_lost); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mr_busy: got %b want 0", busy); end
    rst = 1'b0; en = 1'b0; det_in = 1'b0; rpt_ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_back_to_back();
    test_abort();
    test_win_zero();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
